// File: rtl/lfsr_bert_core.sv
// PRBS bit-error-rate engine: Fibonacci LFSR generator with error injection and a locking checker.
// Optional: define LFSR_BERT_RESYNC_EN to let the unlocked checker reseed from the received stream.
module lfsr_bert_core #(
  parameter int               W                 = 16,
  parameter logic [W-1:0]     TAPS              = 16'hB400,
  parameter int               DEF_SEED          = 300,
  parameter int               VALID_TO_LOCK     = 5,
  parameter int               INVALID_TO_UNLOCK = 3,
  parameter int               CNT_W             = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_soft_reset,
  input  logic [W-1:0]     i_seed,
  input  logic             i_valid,
  input  logic [1:0]       i_inj_mode,
  input  logic [15:0]      i_inj_period,
  input  logic             i_inj_trig,
  output logic [W-1:0]     o_data,
  output logic             o_data_valid,
  input  logic [W-1:0]     i_rx_data,
  input  logic             i_rx_valid,
  input  logic             i_clr_cnt,
  output logic             o_lock,
  output logic [CNT_W-1:0] o_bit_err_cnt,
  output logic [CNT_W-1:0] o_word_err_cnt,
  output logic [CNT_W-1:0] o_word_cnt
);

  localparam int LC_MAX = (VALID_TO_LOCK > INVALID_TO_UNLOCK) ? VALID_TO_LOCK : INVALID_TO_UNLOCK;
  localparam int LC_W   = $clog2(LC_MAX + 1);

  typedef enum logic {UNLOCKED, LOCKED} state_t;

  function automatic logic [W-1:0] lfsr_next(input logic [W-1:0] s);
    return {s[W-2:0], ^(s & TAPS)};
  endfunction

  function automatic logic [CNT_W:0] popcount(input logic [W-1:0] s);
    logic [CNT_W:0] c;
    c = '0;
    for (int i = 0; i < W; i++) c = c + (CNT_W+1)'(s[i]);
    return c;
  endfunction

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [CNT_W:0] b);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + b;
    return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
  endfunction

  logic [W-1:0] seed_eff;
  assign seed_eff = (i_seed == '0) ? W'(DEF_SEED) : i_seed;

  // ---------------- generator and injector ----------------
  logic [W-1:0] gen_q;
  logic [15:0]  per_cnt_q;
  logic         armed_q, trig_q;
  logic [1:0]   mode_q;
  logic         mode_chg, trig_edge, per_hit, inject;
  logic [W-1:0] inj_mask;

  assign mode_chg  = (i_inj_mode != mode_q);
  assign trig_edge = i_inj_trig & ~trig_q;
  assign per_hit   = (i_inj_period <= 16'd1) || (per_cnt_q == i_inj_period - 16'd1);

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    inject = 1'b0;
    case (i_inj_mode)
      2'd1:    inject = armed_q;
      2'd2:    inject = per_hit;
      2'd3:    inject = 1'b1;
      default: inject = 1'b0;
    endcase
  end

  assign inj_mask = {{(W-1){1'b0}}, inject & i_valid};

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      gen_q        <= seed_eff;
      o_data       <= '0;
      o_data_valid <= 1'b0;
      armed_q      <= 1'b0;
      per_cnt_q    <= '0;
      trig_q       <= 1'b0;
      mode_q       <= '0;
    end else if (i_soft_reset) begin
      gen_q        <= seed_eff;
      o_data_valid <= 1'b0;
      armed_q      <= 1'b0;
      per_cnt_q    <= '0;
      trig_q       <= i_inj_trig;
      mode_q       <= i_inj_mode;
    end else begin
      trig_q       <= i_inj_trig;
      mode_q       <= i_inj_mode;
      o_data_valid <= i_valid;
      if (i_valid) begin
        o_data <= gen_q ^ inj_mask;
        gen_q  <= lfsr_next(gen_q);
      end
      if (mode_chg) begin
        armed_q   <= 1'b0;
        per_cnt_q <= '0;
      end else begin
        if (i_inj_mode == 2'd1 && i_valid && armed_q) armed_q <= 1'b0;
        else if (i_inj_mode == 2'd1 && trig_edge)     armed_q <= 1'b1;
        if (i_inj_mode == 2'd2 && i_valid) per_cnt_q <= per_hit ? 16'd0 : per_cnt_q + 16'd1;
      end
    end
  end

  // ---------------- checker ----------------
  state_t       state_q, state_d;
  logic [LC_W-1:0] cnt_q, cnt_d;
  logic [W-1:0] exp_q, exp_d;
  logic [W-1:0] err;
  logic         match;

  assign err    = i_rx_data ^ exp_q;
  assign match  = (err == '0);
  assign o_lock = (state_q == LOCKED);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    exp_d   = exp_q;
    if (i_rx_valid) begin
      exp_d = lfsr_next(exp_q);
`ifdef LFSR_BERT_RESYNC_EN
      if (state_q == UNLOCKED && !match)
        exp_d = lfsr_next((i_rx_data == '0) ? W'(DEF_SEED) : i_rx_data);
`endif
      case (state_q)
        UNLOCKED: begin
          if (!match)                                 cnt_d = '0;
          else if (cnt_q == LC_W'(VALID_TO_LOCK - 1)) begin
            state_d = LOCKED;
            cnt_d   = '0;
          end else                                    cnt_d = cnt_q + 1'b1;
        end
        default: begin
          if (match)                                      cnt_d = '0;
          else if (cnt_q == LC_W'(INVALID_TO_UNLOCK - 1)) begin
            state_d = UNLOCKED;
            cnt_d   = '0;
          end else                                        cnt_d = cnt_q + 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_soft_reset) begin
      state_q <= UNLOCKED;
      cnt_q   <= '0;
      exp_q   <= seed_eff;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
    end
  end

  // Statistics count only words seen while locked, including the word that unlocks.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr_cnt) begin
      o_bit_err_cnt  <= '0;
      o_word_err_cnt <= '0;
      o_word_cnt     <= '0;
    end else if (!i_soft_reset && i_rx_valid && o_lock) begin
      o_word_cnt <= sat_add(o_word_cnt, (CNT_W+1)'(1));
      if (!match) begin
        o_word_err_cnt <= sat_add(o_word_err_cnt, (CNT_W+1)'(1));
        o_bit_err_cnt  <= sat_add(o_bit_err_cnt, popcount(err));
      end
    end
  end

endmodule

// File: tb/tb_lfsr_bert_core.sv
// Directed bench for lfsr_bert_core: lock, periodic/continuous/single-shot injection, offset stream,
// saturation and clear priority. Counters built 6 bits wide so saturation is reachable.
module tb_lfsr_bert_core;

  localparam int W     = 16;
  localparam int CNT_W = 6;
`ifdef LFSR_BERT_RESYNC_EN
  localparam logic RESYNC = 1'b1;
`else
  localparam logic RESYNC = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst, soft_reset, valid, inj_trig, clr_cnt;
  logic [W-1:0]     seed;
  logic [1:0]       inj_mode;
  logic [15:0]      inj_period;
  logic [W-1:0]     data;
  logic             data_valid;
  logic [W-1:0]     rx_data, rx_data_man;
  logic             rx_valid, rx_valid_man, loop_en;
  logic             lock;
  logic [CNT_W-1:0] bit_err_cnt, word_err_cnt, word_cnt;

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] m;

  assign rx_data  = loop_en ? data : rx_data_man;
  assign rx_valid = loop_en ? data_valid : rx_valid_man;

  lfsr_bert_core #(.W(W), .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_rst(rst), .i_soft_reset(soft_reset), .i_seed(seed), .i_valid(valid),
    .i_inj_mode(inj_mode), .i_inj_period(inj_period), .i_inj_trig(inj_trig),
    .o_data(data), .o_data_valid(data_valid), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .i_clr_cnt(clr_cnt), .o_lock(lock), .o_bit_err_cnt(bit_err_cnt),
    .o_word_err_cnt(word_err_cnt), .o_word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] nxt(input logic [W-1:0] s);
    return {s[W-2:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_cmp++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; soft_reset = 1'b0; valid = 1'b0; inj_trig = 1'b0; clr_cnt = 1'b0;
    seed = 16'd300; inj_mode = 2'd0; inj_period = 16'd0;
    rx_data_man = '0; rx_valid_man = 1'b0; loop_en = 1'b1;
    step(); step();
    check("rst_data", data, 0);
    check("rst_dvalid", data_valid, 0);
    check("rst_lock", lock, 0);
    check("rst_cnts", {bit_err_cnt, word_err_cnt, word_cnt}, 0);
    rst = 1'b0;

    // 1: clean loopback, lock after the 5th received word
    for (int i = 0; i < 20; i++) begin
      valid = 1'b1; step();
      if (i == 0) check("t1_w0", data, 16'h012C);
      if (i == 1) check("t1_w1", data, 16'h0258);
      if (i == 2) check("t1_w2", data, 16'h04B0);
      if (i == 3) check("t1_w3", data, 16'h0961);
      if (i == 4) check("t1_lock_early", lock, 0);
      if (i == 5) check("t1_lock", lock, 1);
    end
    valid = 1'b0; step();
    check("t1_word_cnt", word_cnt, 15);
    check("t1_word_err", word_err_cnt, 0);
    check("t1_bit_err", bit_err_cnt, 0);

    // 2: periodic injection every 4th word keeps lock
    inj_mode = 2'd2; inj_period = 16'd4; step();
    for (int i = 0; i < 42; i++) begin valid = 1'b1; step(); end
    valid = 1'b0; step();
    check("t2_word_err", word_err_cnt, 10);
    check("t2_bit_err", bit_err_cnt, 10);
    check("t2_word_cnt", word_cnt, 57);
    check("t2_lock", lock, 1);

    // 3: continuous injection unlocks after 3 bad words, counters then freeze
    clr_cnt = 1'b1; step(); clr_cnt = 1'b0;
    check("t3_clr", word_cnt, 0);
    inj_mode = 2'd3; step();
    for (int i = 0; i < 8; i++) begin
      valid = 1'b1; step();
      if (i == 2) check("t3_lock_held", lock, 1);
      if (i == 3) check("t3_unlock", lock, 0);
    end
    valid = 1'b0; step();
    check("t3_word_err", word_err_cnt, 3);
    check("t3_bit_err", bit_err_cnt, 3);
    check("t3_word_cnt", word_cnt, 3);
    check("t3_lock", lock, 0);

    // 4: soft reset beats valid, seed 0 -> 300, single-shot corrupts exactly one word
    inj_mode = 2'd0; seed = '0; valid = 1'b1; soft_reset = 1'b1; step();
    soft_reset = 1'b0;
    check("t4_sr_dvalid", data_valid, 0);
    check("t4_sr_lock", lock, 0);
    step();
    check("t4_first", data, 16'd300);
    m = nxt(16'd300);
    valid = 1'b0; loop_en = 1'b0;
    inj_mode = 2'd1; step();
    inj_trig = 1'b1; step(); inj_trig = 1'b0; step();
    inj_trig = 1'b1; step(); inj_trig = 1'b0; step();
    for (int k = 0; k < 6; k++) begin
      valid = 1'b1; step();
      check($sformatf("t4_data%0d", k), data, (k == 0) ? (m ^ 16'h0001) : m);
      m = nxt(m);
    end
    valid = 1'b0; step();

    // 5: rx stream offset by 7 words
    inj_mode = 2'd0; seed = 16'd300; soft_reset = 1'b1; step(); soft_reset = 1'b0;
    m = 16'd300;
    for (int k = 0; k < 7; k++) m = nxt(m);
    rx_valid_man = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      rx_data_man = m; step(); m = nxt(m);
      if (k == 5) check("t5_lock5", lock, 0);
      if (k == 6) check("t5_lock6", lock, RESYNC);
    end
    rx_valid_man = 1'b0; step();
    check("t5_lock_end", lock, RESYNC);

    // 6: saturation, then clear beating a same-cycle increment
    loop_en = 1'b1; soft_reset = 1'b1; clr_cnt = 1'b1; step();
    soft_reset = 1'b0; clr_cnt = 1'b0;
    for (int i = 0; i < 10; i++) begin valid = 1'b1; step(); end
    valid = 1'b0; step();
    check("t6_lock", lock, 1);
    inj_mode = 2'd2; inj_period = 16'd2; step();
    for (int i = 0; i < 140; i++) begin valid = 1'b1; step(); end
    check("t6_sat_word_err", word_err_cnt, 63);
    check("t6_sat_bit_err", bit_err_cnt, 63);
    check("t6_sat_word_cnt", word_cnt, 63);
    check("t6_lock_held", lock, 1);
    clr_cnt = 1'b1; step(); clr_cnt = 1'b0;
    check("t6_clr_word_cnt", word_cnt, 0);
    check("t6_clr_word_err", word_err_cnt, 0);
    step();
    check("t6_after_clr", word_cnt, 1);
    valid = 1'b0; step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
